// File: rtl/tx_arbiter_pkg.sv
// tx_arbiter_pkg -- shared types and constants for the TX arbiter slice.
//   tx_state_e         : frame FSM states (IDLE, START, HEADER, PAYLOAD)
//   owner_t            : requester ID, OWNER_SCH = 0, OWNER_PF = 1
//   TX_START_BIT       : level driven on lane 0 during START (other lanes low)
//   TX_PREAMBLE_CYCLES : START + HEADER cycles ahead of the payload
//   REPLY_FIFO_DEPTH   : outstanding RX replies tracked
package tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_HEADER,
    ST_PAYLOAD
  } tx_state_e;

  typedef logic owner_t;

  localparam owner_t OWNER_SCH = 1'b0;
  localparam owner_t OWNER_PF  = 1'b1;

  localparam logic        TX_START_BIT       = 1'b1;
  localparam int unsigned TX_PREAMBLE_CYCLES = 2;
  localparam int unsigned REPLY_FIFO_DEPTH   = 2;

endpackage

// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if -- request/grant handshake bundle between the two TX
// requesters (scheduler, prefetch) and the arbiter.
//   master : requester side, drives *_valid/cmd/data, sees *_started/*_data_next
//   slave  : arbiter side, the mirror image
interface tx_arbiter_if #(
  parameter int NSHIFT   = 2,
  parameter int CMD_BITS = 2
);
  logic                sch_valid;
  logic [CMD_BITS-1:0] sch_cmd;
  logic                sch_reply;
  logic                sch_reserve;
  logic [NSHIFT-1:0]   sch_data;
  logic                pf_valid;
  logic [CMD_BITS-1:0] pf_cmd;
  logic [NSHIFT-1:0]   pf_data;
  logic                sch_started;
  logic                pf_started;
  logic                sch_data_next;
  logic                pf_data_next;

  modport master (
    output sch_valid, sch_cmd, sch_reply, sch_reserve, sch_data,
    output pf_valid, pf_cmd, pf_data,
    input  sch_started, pf_started, sch_data_next, pf_data_next
  );

  modport slave (
    input  sch_valid, sch_cmd, sch_reply, sch_reserve, sch_data,
    input  pf_valid, pf_cmd, pf_data,
    output sch_started, pf_started, sch_data_next, pf_data_next
  );
endinterface

// File: rtl/tx_arbiter_reply_owner_fifo.sv
// reply_owner_fifo -- two-entry FIFO of requester IDs awaiting an RX reply.
//   clk, reset    : clock, synchronous active-high reset
//   push_i        : record push_owner_i (caller never pushes into a full FIFO
//                   unless pop_i is also high)
//   pop_i         : RX reply completed; ignored while empty
//   head_o        : oldest owner (0 when empty)
//   valid_o       : FIFO non-empty
//   full_o        : FIFO holds REPLY_FIFO_DEPTH entries
module reply_owner_fifo
  import tx_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  owner_t push_owner_i,
  input  logic   pop_i,
  output owner_t head_o,
  output logic   valid_o,
  output logic   full_o
);

  logic [1:0] mem_q, mem_d;   // mem_q[0] is the head
  logic [1:0] count_q, count_d;
  logic       pop_en;

  // Pop is applied before push so a full FIFO can accept a push in the
  // same cycle a reply retires.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    pop_en  = pop_i && (count_q != '0);
    if (pop_en) begin
      mem_d[0] = mem_q[1];
      count_d  = count_q - 2'd1;
    end
    if (push_i && (count_d != 2'(REPLY_FIFO_DEPTH))) begin
      mem_d[count_d[0]] = push_owner_i;
      count_d           = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == 2'(REPLY_FIFO_DEPTH));
  assign head_o  = valid_o ? mem_q[0] : OWNER_SCH;

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter -- arbitrates the TX serial link between the scheduler and the
// prefetcher and serialises one frame per grant:
//   START (lane0 = 1), HEADER (latched command), PAYLOAD_CYCLES of owner data.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   sch_* / pf_*         : requester command, payload and handshake
//   rx_done              : an RX reply frame completed (retires oldest owner)
//   tx_active/tx_counter : frame in progress / cycle index within frame
//   tx_done              : last frame cycle
//   tx_pins              : serial output lanes
//   rx_owner(_valid)     : owner of oldest outstanding reply
// Build option: define TX_ARB_ROUND_ROBIN_EN to alternate grants when both
// requesters are eligible; otherwise the scheduler always wins.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int CMD_BITS       = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sch_valid,
  input  logic [CMD_BITS-1:0]               sch_cmd,
  input  logic                              sch_reply,
  input  logic                              sch_reserve,
  input  logic [NSHIFT-1:0]                 sch_data,
  input  logic                              pf_valid,
  input  logic [CMD_BITS-1:0]               pf_cmd,
  input  logic [NSHIFT-1:0]                 pf_data,
  input  logic                              rx_done,
  output logic                              sch_started,
  output logic                              pf_started,
  output logic                              sch_data_next,
  output logic                              pf_data_next,
  output logic                              tx_active,
  output logic [$clog2(PAYLOAD_CYCLES):0]   tx_counter,
  output logic                              tx_done,
  output logic [NSHIFT-1:0]                 tx_pins,
  output logic                              rx_owner,
  output logic                              rx_owner_valid
);

  localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;
  localparam logic [CW-1:0] FIRST_PAY_CNT = CW'(TX_PREAMBLE_CYCLES);
  localparam logic [CW-1:0] LAST_CNT      = CW'(PAYLOAD_CYCLES + TX_PREAMBLE_CYCLES - 1);

  tx_state_e           state_q;
  logic [CW-1:0]       cnt_q;
  logic [CMD_BITS-1:0] cmd_q;
  owner_t              owner_q;
  logic                active_q;
  logic                done_q;
`ifdef TX_ARB_ROUND_ROBIN_EN
  owner_t              last_q;
`endif

  logic in_last, can_grant, room, sch_elig, pf_elig;
  logic grant_sch, grant_pf, push;
  logic fifo_full;

  // A requester that needs a reply may use the slot an rx_done frees this
  // same cycle; the FIFO pops before it pushes.
  always_comb begin
    in_last   = (state_q == ST_PAYLOAD) && (cnt_q == LAST_CNT);
    can_grant = !reset && ((state_q == ST_IDLE) || in_last);
    room      = !fifo_full || rx_done;
    sch_elig  = sch_valid && (!sch_reply || room);
    pf_elig   = pf_valid && !sch_reserve && room;
`ifdef TX_ARB_ROUND_ROBIN_EN
    grant_sch = can_grant && sch_elig && (!pf_elig || (last_q == OWNER_PF));
`else
    grant_sch = can_grant && sch_elig;
`endif
    grant_pf  = can_grant && pf_elig && !grant_sch;
    push      = grant_pf || (grant_sch && sch_reply);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      owner_q  <= OWNER_SCH;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef TX_ARB_ROUND_ROBIN_EN
      last_q   <= OWNER_PF;
`endif
    end else begin
      if (grant_sch || grant_pf) begin
        cmd_q   <= grant_pf ? pf_cmd : sch_cmd;
        owner_q <= grant_pf ? OWNER_PF : OWNER_SCH;
`ifdef TX_ARB_ROUND_ROBIN_EN
        last_q  <= grant_pf ? OWNER_PF : OWNER_SCH;
`endif
      end
      case (state_q)
        ST_IDLE: begin
          cnt_q    <= '0;
          done_q   <= 1'b0;
          active_q <= grant_sch || grant_pf;
          state_q  <= (grant_sch || grant_pf) ? ST_START : ST_IDLE;
        end
        ST_START: begin
          state_q  <= ST_HEADER;
          cnt_q    <= CW'(1);
          active_q <= 1'b1;
          done_q   <= 1'b0;
        end
        ST_HEADER: begin
          state_q  <= ST_PAYLOAD;
          cnt_q    <= FIRST_PAY_CNT;
          active_q <= 1'b1;
          done_q   <= (FIRST_PAY_CNT == LAST_CNT);
        end
        ST_PAYLOAD: begin
          if (in_last) begin
            state_q  <= (grant_sch || grant_pf) ? ST_START : ST_IDLE;
            active_q <= grant_sch || grant_pf;
            cnt_q    <= '0;
            done_q   <= 1'b0;
          end else begin
            cnt_q    <= cnt_q + CW'(1);
            active_q <= 1'b1;
            done_q   <= ((cnt_q + CW'(1)) == LAST_CNT);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          cnt_q    <= '0;
          active_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    tx_pins = '0;
    case (state_q)
      ST_START:   tx_pins[0] = TX_START_BIT;
      ST_HEADER:  tx_pins    = NSHIFT'(cmd_q);
      ST_PAYLOAD: tx_pins    = (owner_q == OWNER_PF) ? pf_data : sch_data;
      default:    tx_pins    = '0;
    endcase
  end

  // Pulses are masked during reset so an aborted frame emits nothing.
  assign sch_started   = grant_sch;
  assign pf_started    = grant_pf;
  assign sch_data_next = !reset && (state_q == ST_PAYLOAD) && (owner_q == OWNER_SCH);
  assign pf_data_next  = !reset && (state_q == ST_PAYLOAD) && (owner_q == OWNER_PF);
  assign tx_active     = active_q;
  assign tx_counter    = cnt_q;
  assign tx_done       = done_q && !reset;

  reply_owner_fifo u_reply_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_owner_i (grant_pf ? OWNER_PF : OWNER_SCH),
    .pop_i        (rx_done),
    .head_o       (rx_owner),
    .valid_o      (rx_owner_valid),
    .full_o       (fifo_full)
  );

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter -- self-checking bench for tx_arbiter (PAYLOAD_CYCLES = 8).
// Expected grant owners are queued as requests are driven and retired by a
// monitor whenever the DUT raises a *_started pulse; frame shape, reply FIFO
// and reset behaviour are checked directly. Honours TX_ARB_ROUND_ROBIN_EN.
module tb_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic       tx_active, tx_done, rx_owner, rx_owner_valid;
  logic [3:0] tx_counter;
  logic [1:0] tx_pins;

  int n_vec = 0;
  int n_err = 0;
  logic exp_owner_q[$];   // 0 = scheduler, 1 = prefetch

  always #5 clk = ~clk;

  tx_arbiter_if #(.NSHIFT(2), .CMD_BITS(2)) arb_if ();

  tx_arbiter #(.NSHIFT(2), .PAYLOAD_CYCLES(8), .CMD_BITS(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .sch_valid      (arb_if.sch_valid),
    .sch_cmd        (arb_if.sch_cmd),
    .sch_reply      (arb_if.sch_reply),
    .sch_reserve    (arb_if.sch_reserve),
    .sch_data       (arb_if.sch_data),
    .pf_valid       (arb_if.pf_valid),
    .pf_cmd         (arb_if.pf_cmd),
    .pf_data        (arb_if.pf_data),
    .rx_done        (rx_done),
    .sch_started    (arb_if.sch_started),
    .pf_started     (arb_if.pf_started),
    .sch_data_next  (arb_if.sch_data_next),
    .pf_data_next   (arb_if.pf_data_next),
    .tx_active      (tx_active),
    .tx_counter     (tx_counter),
    .tx_done        (tx_done),
    .tx_pins        (tx_pins),
    .rx_owner       (rx_owner),
    .rx_owner_valid (rx_owner_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Grant scoreboard: encoded {pf_started, sch_started}.
  always @(negedge clk) begin
    if (arb_if.sch_started || arb_if.pf_started) begin
      if (exp_owner_q.size() == 0) begin
        check_eq("grant_unexpected", {30'd0, arb_if.pf_started, arb_if.sch_started}, 32'd0);
      end else begin
        check_eq("grant_owner", {30'd0, arb_if.pf_started, arb_if.sch_started},
                 exp_owner_q[0] ? 32'd2 : 32'd1);
        void'(exp_owner_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arb_if.sch_valid   = 1'b0;
    arb_if.sch_cmd     = '0;
    arb_if.sch_reply   = 1'b0;
    arb_if.sch_reserve = 1'b0;
    arb_if.sch_data    = '0;
    arb_if.pf_valid    = 1'b0;
    arb_if.pf_cmd      = '0;
    arb_if.pf_data     = '0;
    rx_done            = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_reached"}, 32'(seen), 32'd1);
  endtask

  initial begin
    do_reset();

    // Reset state
    @(negedge clk);
    check_eq("rst_active",   32'(tx_active), 32'd0);
    check_eq("rst_counter",  32'(tx_counter), 32'd0);
    check_eq("rst_pins",     32'(tx_pins), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_owner_valid), 32'd0);
    check_eq("rst_done",     32'(tx_done), 32'd0);

    // Single prefetch frame; pf_valid dropped right after the grant
    tick();
    arb_if.pf_valid = 1'b1;
    arb_if.pf_cmd   = 2'b10;
    arb_if.pf_data  = 2'b11;
    exp_owner_q.push_back(1'b1);
    @(negedge clk);
    check_eq("pf_started_t0", 32'(arb_if.pf_started), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      arb_if.pf_valid = 1'b0;
      @(negedge clk);
      check_eq("frame_pins", 32'(tx_pins), (k == 1) ? 32'd1 : (k == 2) ? 32'd2 : 32'd3);
      check_eq("frame_counter", 32'(tx_counter), (k == 1) ? 32'd0 : 32'(k - 1));
      check_eq("frame_done", 32'(tx_done), (k == 10) ? 32'd1 : 32'd0);
      check_eq("frame_active", 32'(tx_active), 32'd1);
      check_eq("frame_pf_next", 32'(arb_if.pf_data_next), (k >= 3) ? 32'd1 : 32'd0);
      check_eq("frame_sch_next", 32'(arb_if.sch_data_next), 32'd0);
    end
    tick();
    @(negedge clk);
    check_eq("post_frame_idle", 32'(tx_active), 32'd0);
    check_eq("reply_pf_owner", {30'd0, rx_owner_valid, rx_owner}, 32'd3);
    tick();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    @(negedge clk);
    check_eq("reply_popped", 32'(rx_owner_valid), 32'd0);

    // Both request together: scheduler first, prefetch chained at its tx_done
    do_reset();
    arb_if.sch_valid = 1'b1;
    arb_if.sch_cmd   = 2'b01;
    arb_if.sch_data  = 2'b01;
    arb_if.pf_valid  = 1'b1;
    arb_if.pf_cmd    = 2'b11;
    arb_if.pf_data   = 2'b10;
    exp_owner_q.push_back(1'b0);
    exp_owner_q.push_back(1'b1);
    @(negedge clk);
    check_eq("prio_sch_started", 32'(arb_if.sch_started), 32'd1);
    check_eq("prio_pf_held",     32'(arb_if.pf_started), 32'd0);
    tick();
    arb_if.sch_valid = 1'b0;
    wait_done("prio_sch_done");
    check_eq("prio_pf_at_done", 32'(arb_if.pf_started), 32'd1);
    check_eq("prio_sch_pins",   32'(tx_pins), 32'd1);
    check_eq("prio_sch_next",   32'(arb_if.sch_data_next), 32'd1);
    tick();
    arb_if.pf_valid = 1'b0;
    @(negedge clk);
    check_eq("prio_pf_start_cnt",  32'(tx_counter), 32'd0);
    check_eq("prio_pf_start_pins", 32'(tx_pins), 32'd1);
    tick();
    @(negedge clk);
    check_eq("prio_pf_header", 32'(tx_pins), 32'd3);

    // Reserve blocks prefetch even with no scheduler request
    do_reset();
    arb_if.sch_reserve = 1'b1;
    arb_if.pf_valid    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("reserve_blocks_pf", 32'(arb_if.pf_started), 32'd0);
      tick();
    end
    arb_if.sch_reserve = 1'b0;
    exp_owner_q.push_back(1'b1);
    @(negedge clk);
    check_eq("reserve_release_pf", 32'(arb_if.pf_started), 32'd1);
    tick();
    arb_if.pf_valid = 1'b0;

    // Reply FIFO fills after two prefetch reads; rx_done frees a slot in-cycle
    do_reset();
    arb_if.pf_valid = 1'b1;
    arb_if.pf_data  = 2'b01;
    exp_owner_q.push_back(1'b1);
    exp_owner_q.push_back(1'b1);
    wait_done("fifo_frame1");
    wait_done("fifo_frame2");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("fifo_full_stall", 32'(arb_if.pf_started), 32'd0);
      check_eq("fifo_full_idle",  32'(tx_active), 32'd0);
    end
    tick();
    rx_done = 1'b1;
    exp_owner_q.push_back(1'b1);
    @(negedge clk);
    check_eq("fifo_pop_push_grant", 32'(arb_if.pf_started), 32'd1);
    tick();
    rx_done         = 1'b0;
    arb_if.pf_valid = 1'b0;
    @(negedge clk);
    check_eq("fifo_head_pf", {30'd0, rx_owner_valid, rx_owner}, 32'd3);
    tick();
    rx_done = 1'b1;       // three pops: two entries, then one while empty
    tick();
    tick();
    tick();
    rx_done = 1'b0;
    @(negedge clk);
    check_eq("fifo_drained", {30'd0, rx_owner_valid, rx_owner}, 32'd0);
    wait_done("fifo_frame3");

    // Reset mid-frame at tx_counter = 5
    do_reset();
    arb_if.sch_valid = 1'b1;
    arb_if.sch_reply = 1'b1;
    arb_if.sch_cmd   = 2'b10;
    arb_if.sch_data  = 2'b10;
    exp_owner_q.push_back(1'b0);
    tick();
    arb_if.sch_valid = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (tx_counter == 4'd5) begin
          seen = 1'b1;
          break;
        end
      end
      check_eq("midrst_cnt5_reached", 32'(seen), 32'd1);
    end
    check_eq("midrst_reply_sch", {30'd0, rx_owner_valid, rx_owner}, 32'd2);
    reset = 1'b1;
    tick();
    arb_if.sch_valid = 1'b1;
    @(negedge clk);
    check_eq("midrst_idle",     32'(tx_active), 32'd0);
    check_eq("midrst_pins",     32'(tx_pins), 32'd0);
    check_eq("midrst_counter",  32'(tx_counter), 32'd0);
    check_eq("midrst_rx_valid", 32'(rx_owner_valid), 32'd0);
    check_eq("midrst_no_start", 32'(arb_if.sch_started), 32'd0);
    check_eq("midrst_no_done",  32'(tx_done), 32'd0);
    tick();
    reset = 1'b0;
    arb_if.sch_valid = 1'b0;

    // Both requesters held continuously
    do_reset();
    arb_if.sch_valid = 1'b1;
    arb_if.pf_valid  = 1'b1;
`ifdef TX_ARB_ROUND_ROBIN_EN
    exp_owner_q.push_back(1'b0);
    exp_owner_q.push_back(1'b1);
    exp_owner_q.push_back(1'b0);
    exp_owner_q.push_back(1'b1);
    wait_done("rr_frame1");
    wait_done("rr_frame2");
    wait_done("rr_frame3");
`else
    exp_owner_q.push_back(1'b0);
    exp_owner_q.push_back(1'b0);
    exp_owner_q.push_back(1'b0);
    wait_done("fixed_frame1");
    wait_done("fixed_frame2");
`endif
    tick();
    arb_if.sch_valid = 1'b0;
    arb_if.pf_valid  = 1'b0;
    wait_done("both_last_frame");
    tick();
    tick();

    check_eq("grant_queue_drained", 32'(exp_owner_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
